count_arbiter: RTL

- Sequences the shared digit-counter increment path and the display refresh path.
- Captures rising edges on the synchronized per-digit request lanes into sticky pending bits.
- Grants pending lanes one at a time, round-robin, as a single-cycle one-hot increment pulse.
- After every grant it waits a settle time, then runs a request/busy handshake with the serial display shifter, so one counter update is always fully displayed before the next is issued.

---
 rtl/count_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/count_arbiter.sv
// count_arbiter: grants digit increment pulses round-robin, one at a time, and
// holds off the next grant until the display shifter has finished its refresh.
module count_arbiter #(
  parameter int DIGITS        = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIGITS-1:0] req_in,
  output logic [DIGITS-1:0] inc_out,
  output logic              refresh_req,
  input  logic              refresh_busy,
  output logic              busy,
  output logic              drop_err,
  output logic              timeout_err
);

  localparam int PTR_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  localparam logic [DIGITS-1:0] ONE         = DIGITS'(1);
  localparam logic [PTR_W:0]    NUM_LANES   = (PTR_W + 1)'(DIGITS);
  localparam logic [PTR_W-1:0]  LAST_LANE   = PTR_W'(DIGITS - 1);
  localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TMO_LAST    = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    SETTLE,
    REFRESH_REQ,
    REFRESH_WAIT
  } state_t;

  state_t            state, state_n;
  logic [DIGITS-1:0] req_s, req_q, pending, evt, clr;
  logic [PTR_W-1:0]  ptr, ptr_n, win, win_n, pick;
  logic [SCNT_W-1:0] scnt, scnt_n;
  logic [TCNT_W-1:0] tcnt, tcnt_n;
  logic [DIGITS-1:0] inc_n;
  logic              refresh_req_n, tmo;

  // req_in is sampled once and edges are taken on that copy, so an event
  // reaches pending one edge after it is first sampled.
  assign evt = req_s & ~req_q;

  // NOTE: every flop is written with <= so all registers update from the
  // values seen before the edge, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_s    <= '0;
      req_q    <= '0;
      pending  <= '0;
      drop_err <= 1'b0;
    end else begin
      req_s   <= req_in;
      req_q   <= req_s;
      pending <= (pending & ~clr) | evt;
      if (|(evt & pending & ~clr)) drop_err <= 1'b1;
    end
  end

  // Round-robin search: first pending lane at or above ptr, wrapping.
  always_comb begin
    logic           found;
    logic [PTR_W:0] sum;
    found = 1'b0;
    sum   = '0;
    pick  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      sum = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (sum >= NUM_LANES) sum = sum - NUM_LANES;
      if (!found && pending[sum[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = sum[PTR_W-1:0];
      end
    end
  end

  // NOTE: every variable gets a default before the case so no path through
  // this block can leave a value unassigned and infer a latch.
  always_comb begin
    state_n       = state;
    win_n         = win;
    ptr_n         = ptr;
    scnt_n        = scnt;
    tcnt_n        = tcnt;
    inc_n         = '0;
    refresh_req_n = 1'b0;
    clr           = '0;
    tmo           = 1'b0;
    unique case (state)
      IDLE: begin
        if (|pending) begin
          state_n = GRANT;
          win_n   = pick;
          inc_n   = ONE << pick;
        end
      end
      GRANT: begin
        clr     = ONE << win;
        ptr_n   = (win == LAST_LANE) ? '0 : win + 1'b1;
        scnt_n  = '0;
        state_n = SETTLE;
      end
      SETTLE: begin
        if (scnt == SETTLE_LAST) begin
          state_n       = REFRESH_REQ;
          refresh_req_n = 1'b1;
          tcnt_n        = '0;
        end else begin
          scnt_n = scnt + 1'b1;
        end
      end
      REFRESH_REQ: begin
        if (tcnt == TMO_LAST) begin
          tmo     = 1'b1;
          state_n = IDLE;
        end else if (refresh_busy) begin
          state_n = REFRESH_WAIT;
          tcnt_n  = tcnt + 1'b1;
        end else begin
          refresh_req_n = 1'b1;
          tcnt_n        = tcnt + 1'b1;
        end
      end
      REFRESH_WAIT: begin
        // The budget spans both handshake states; exhaustion wins a tie.
        if (tcnt == TMO_LAST) begin
          tmo     = 1'b1;
          state_n = IDLE;
        end else if (!refresh_busy) begin
          state_n = IDLE;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      win         <= '0;
      scnt        <= '0;
      tcnt        <= '0;
      inc_out     <= '0;
      refresh_req <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      win         <= win_n;
      scnt        <= scnt_n;
      tcnt        <= tcnt_n;
      inc_out     <= inc_n;
      refresh_req <= refresh_req_n;
      busy        <= (state_n != IDLE);
      if (tmo) timeout_err <= 1'b1;
    end
  end

endmodule
